// File: rtl/core_mrpnwp_rd_issue.sv
// core_mrpnwp_rd_issue: registered SRAM read issue with delay-matched return tracking
module core_mrpnwp_rd_issue #(
    parameter int NUMRDPT    = 2,
    parameter int NUMADDR    = 8192,
    parameter int BITADDR    = 13,
    parameter int NUMVBNK    = 8,
    parameter int BITVBNK    = 3,
    parameter int BITVROW    = 10,
    parameter int BITPADR    = 13,
    parameter int SRAM_DELAY = 2,
    parameter int CNTW       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ready,
    input  logic [NUMRDPT-1:0]           pread,
    input  logic [NUMRDPT*BITADDR-1:0]   prdadr,
    output logic [NUMRDPT*NUMVBNK-1:0]   t1_readA,
    output logic [NUMRDPT*BITVROW-1:0]   t1_addrA,
    output logic [NUMRDPT-1:0]           vread_vld_bus,
    output logic [NUMRDPT*BITPADR-1:0]   vread_padr_bus,
    output logic [NUMRDPT-1:0]           vread_oor,
    output logic [NUMRDPT*CNTW-1:0]      rd_cnt,
    output logic                         busy
);
    logic [NUMRDPT-1:0]                              acc, oor;
    logic [NUMRDPT-1:0][BITVBNK-1:0]                 bank;
    logic [NUMRDPT-1:0][BITVROW-1:0]                 row;
    logic [NUMRDPT-1:0][NUMVBNK-1:0]                 rd_en_q, rd_en_d;
    logic [NUMRDPT-1:0][BITVROW-1:0]                 rd_row_q, rd_row_d;
    logic [NUMRDPT-1:0]                              iss_vld_q, iss_vld_d, iss_oor_q, iss_oor_d;
    logic [NUMRDPT-1:0][BITPADR-1:0]                 iss_padr_q, iss_padr_d;
    logic [SRAM_DELAY-1:0][NUMRDPT-1:0]              pipe_vld_q, pipe_vld_d, pipe_oor_q, pipe_oor_d;
    logic [SRAM_DELAY-1:0][NUMRDPT-1:0][BITPADR-1:0] pipe_padr_q, pipe_padr_d;
    logic [NUMRDPT-1:0][CNTW-1:0]                    cnt_q, cnt_d;

    genvar g;
    for (g = 0; g < NUMRDPT; g++) begin : g_dec
        logic [BITADDR-1:0] adr;
        assign adr     = prdadr[g*BITADDR +: BITADDR];
        assign bank[g] = adr[BITVBNK-1:0];
        assign row[g]  = adr[BITADDR-1:BITVBNK];
        assign acc[g]  = pread[g] & ready;
        assign oor[g]  = {{(32-BITADDR){1'b0}}, adr} >= NUMADDR;
    end

    // issue stage: one-hot bank enable, row, tracked padr/oor and saturating counters
    always_comb begin
        rd_en_d    = '0;
        rd_row_d   = '0;
        iss_padr_d = '0;
        iss_vld_d  = acc;
        iss_oor_d  = acc & oor;
        cnt_d      = cnt_q;
        for (int i = 0; i < NUMRDPT; i++) begin
            rd_en_d[i]    = (acc[i] && !oor[i]) ? {{(NUMVBNK-1){1'b0}}, 1'b1} << bank[i] : '0;
            rd_row_d[i]   = acc[i] ? row[i] : '0;
            iss_padr_d[i] = acc[i] ? {bank[i], row[i]} : '0;
            cnt_d[i]      = cnt_q[i] + CNTW'(acc[i] && cnt_q[i] != '1);
        end
    end

    // return pipeline: shift issue-stage tracking through the SRAM latency
    always_comb begin
        pipe_vld_d     = pipe_vld_q;
        pipe_oor_d     = pipe_oor_q;
        pipe_padr_d    = pipe_padr_q;
        pipe_vld_d[0]  = iss_vld_q;
        pipe_oor_d[0]  = iss_oor_q;
        pipe_padr_d[0] = iss_padr_q;
        for (int s = 1; s < SRAM_DELAY; s++) begin
            pipe_vld_d[s]  = pipe_vld_q[s-1];
            pipe_oor_d[s]  = pipe_oor_q[s-1];
            pipe_padr_d[s] = pipe_padr_q[s-1];
        end
    end

    // state registers; reset drops every in-flight read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_q     <= '0;
            rd_row_q    <= '0;
            iss_vld_q   <= '0;
            iss_oor_q   <= '0;
            iss_padr_q  <= '0;
            pipe_vld_q  <= '0;
            pipe_oor_q  <= '0;
            pipe_padr_q <= '0;
            cnt_q       <= '0;
        end else begin
            rd_en_q     <= rd_en_d;
            rd_row_q    <= rd_row_d;
            iss_vld_q   <= iss_vld_d;
            iss_oor_q   <= iss_oor_d;
            iss_padr_q  <= iss_padr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_oor_q  <= pipe_oor_d;
            pipe_padr_q <= pipe_padr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign t1_readA       = rd_en_q;
    assign t1_addrA       = rd_row_q;
    assign vread_vld_bus  = pipe_vld_q[SRAM_DELAY-1];
    assign vread_oor      = pipe_oor_q[SRAM_DELAY-1];
    assign vread_padr_bus = pipe_padr_q[SRAM_DELAY-1];
    assign rd_cnt         = cnt_q;
    assign busy           = |iss_vld_q || |pipe_vld_q;
endmodule

// File: tb/tb_core_mrpnwp_rd_issue.sv
// tb_core_mrpnwp_rd_issue: scoreboard bench for the read issue stage
module tb_core_mrpnwp_rd_issue;
    localparam int NA = 6000;
    localparam int D  = 2;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst, ready;
    logic [1:0]  pread;
    logic [25:0] prdadr;
    logic [15:0] t1_readA;
    logic [19:0] t1_addrA;
    logic [1:0]  vld, voor;
    logic [25:0] vpadr;
    logic [7:0]  rd_cnt;
    logic        busy;

    always #5 clk = ~clk;

    core_mrpnwp_rd_issue #(.NUMADDR(NA), .SRAM_DELAY(D), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .ready(ready), .pread(pread), .prdadr(prdadr),
        .t1_readA(t1_readA), .t1_addrA(t1_addrA), .vread_vld_bus(vld),
        .vread_padr_bus(vpadr), .vread_oor(voor), .rd_cnt(rd_cnt), .busy(busy)
    );

    typedef struct {int due; int port; int a; int b;} ev_t;
    ev_t iq[$], rq[$], cq[$];
    int  acc_cyc[$];
    int  cyc = 0, checks = 0, failures = 0;
    int  cnt_m[2] = '{0, 0};
    int  cnt_cur[2] = '{0, 0};
    int  e_ra[2], e_row[2], e_v[2], e_p[2], e_o[2];
    bit  e_busy;
    ev_t e;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit rdy, input bit [1:0] pr, input int a0, input int a1);
        bit any;
        @(posedge clk);
        #1;
        rst    = r;
        ready  = rdy;
        pread  = pr;
        prdadr = {a1[12:0], a0[12:0]};
        any    = 0;
        if (r) begin
            iq.delete(); rq.delete(); cq.delete(); acc_cyc.delete();
            cnt_m   = '{0, 0};
            cnt_cur = '{0, 0};
        end else begin
            for (int p = 0; p < 2; p++) begin
                int a, bk, rw;
                bit o;
                a  = (p == 1 ? a1 : a0) % 8192;
                bk = a % 8;
                rw = a / 8;
                o  = a >= NA;
                if (pr[p] && rdy) begin
                    any = 1;
                    iq.push_back('{cyc + 1, p, o ? 0 : (1 << bk), rw});
                    rq.push_back('{cyc + 1 + D, p, bk * 1024 + rw, int'(o)});
                    if (cnt_m[p] < (1 << CW) - 1) cnt_m[p]++;
                    cq.push_back('{cyc + 1, p, cnt_m[p], 0});
                end
            end
            if (any) acc_cyc.push_back(cyc);
        end
    endtask

    always @(negedge clk) begin
        e_ra  = '{0, 0}; e_row = '{0, 0}; e_v = '{0, 0}; e_p = '{0, 0}; e_o = '{0, 0};
        while (iq.size() > 0 && iq[0].due == cyc) begin
            e = iq.pop_front();
            e_ra[e.port]  = e.a;
            e_row[e.port] = e.b;
        end
        while (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            e_v[e.port] = 1;
            e_p[e.port] = e.a;
            e_o[e.port] = e.b;
        end
        while (cq.size() > 0 && cq[0].due == cyc) begin
            e = cq.pop_front();
            cnt_cur[e.port] = e.a;
        end
        while (acc_cyc.size() > 0 && acc_cyc[0] + 1 + D < cyc) void'(acc_cyc.pop_front());
        e_busy = acc_cyc.size() > 0 && acc_cyc[0] + 1 <= cyc;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("readA%0d", p), 32'(t1_readA[p*8 +: 8]), e_ra[p]);
            chk($sformatf("addrA%0d", p), 32'(t1_addrA[p*10 +: 10]), e_row[p]);
            chk($sformatf("vld%0d", p), 32'(vld[p]), e_v[p]);
            chk($sformatf("padr%0d", p), 32'(vpadr[p*13 +: 13]), e_p[p]);
            chk($sformatf("oor%0d", p), 32'(voor[p]), e_o[p]);
            chk($sformatf("rd_cnt%0d", p), 32'(rd_cnt[p*4 +: 4]), cnt_cur[p]);
        end
        chk("busy", 32'(busy), 32'(e_busy));
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 1, 2'b00, 0, 0);
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; pread = '0; prdadr = '0;
        drive(1, 0, 2'b00, 0, 0);
        drive(1, 0, 2'b00, 0, 0);
        // single read of 0x0015: bank 5, row 2
        drive(0, 1, 2'b01, 'h15, 0);
        idle(5);
        // back-to-back on both ports
        for (int k = 0; k < 20; k++) drive(0, 1, 2'b11, 100 + k, 4000 + 3 * k);
        idle(5);
        // out-of-range and boundary addresses
        drive(0, 1, 2'b11, NA, NA - 1);
        drive(0, 1, 2'b11, 8191, 0);
        idle(5);
        // ready low blocks acceptance; ready dropping after an accept
        drive(0, 0, 2'b11, 7, 9);
        drive(0, 0, 2'b11, 7, 9);
        drive(0, 1, 2'b01, 7, 9);
        drive(0, 0, 2'b11, 8, 10);
        drive(0, 0, 2'b00, 0, 0);
        idle(5);
        // reset at N+2 of an in-flight read
        drive(0, 1, 2'b11, 33, 44);
        idle(1);
        drive(1, 1, 2'b00, 0, 0);
        idle(6);
        // randomized traffic with occasional reset
        for (int k = 0; k < 400; k++)
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 2'($urandom),
                  $urandom_range(0, 8191), $urandom_range(0, 8191));
        idle(5);
        // counter saturation
        drive(1, 0, 2'b00, 0, 0);
        for (int k = 0; k < 20; k++) drive(0, 1, 2'b01, k, 0);
        idle(8);
        chk("sb_empty", 32'(iq.size() + rq.size() + cq.size()), 0);
        chk("sat_cnt", 32'(rd_cnt[3:0]), 15);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/core_mrpnwp_rd_issue.md
Name: core_mrpnwp_rd_issue

Overview:
- Read-issue and return-tracking stage that sits between the multiport core's physical read requests and the SRAM bank array.
- Accepts per-port read strobes and addresses, and decodes each address into a virtual bank and row.
- Drives registered read requests into the t1 SRAM macros.
- Delay-matches valid and physical address through the SRAM latency, producing vread_vld_bus and vread_padr_bus for the core output stage.

Parameters:
- NUMRDPT, 2: number of read ports.
- NUMADDR, 8192: number of legal logical addresses.
- BITADDR, 13: logical address width.
- NUMVBNK, 8: number of virtual banks.
- BITVBNK, 3: bank index width.
- BITVROW, 10: row index width; BITVBNK+BITVROW must equal BITADDR.
- BITPADR, 13: physical address width; equals BITADDR.
- SRAM_DELAY, 2: SRAM read latency in cycles, measured from t1_readA to data valid; range 1..8.
- CNTW, 16: width of the per-port issue counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ready  in  1  core ready; reads are accepted only while high.
- pread  in  NUMRDPT  per-port read strobe.
- prdadr  in  NUMRDPT*BITADDR  per-port read address, port i at bits [i*BITADDR +: BITADDR].
- t1_readA  out  NUMRDPT*NUMVBNK  one-hot bank read enable per port.
- t1_addrA  out  NUMRDPT*BITVROW  row address per port.
- vread_vld_bus  out  NUMRDPT  read data valid, aligned with t1_doutB.
- vread_padr_bus  out  NUMRDPT*BITPADR  physical address of the returning read.
- vread_oor  out  NUMRDPT  returning read was out of range; its data is undefined.
- rd_cnt  out  NUMRDPT*CNTW  saturating count of accepted reads per port.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset (async, rst=1): every output and internal flop goes to 0 immediately. In-flight reads are discarded and no valid is produced for them after reset release.
- Accept condition: port i accepts in cycle N when pread[i] && ready. With ready=0 the strobe is ignored; the request is neither counted nor tracked.
- Decode:
  - bank = prdadr[BITVBNK-1:0]
  - row = prdadr[BITADDR-1:BITVBNK]
  - padr = {bank,row}
- Out of range: an address >= NUMADDR is still accepted and counted. For such a read:
  - t1_readA for that port stays all-zero (no SRAM access);
  - oor=1 is carried down the pipeline.
- Issue stage (registered), cycle N+1:
  - t1_readA[i*NUMVBNK+bank]=1 with all other bits of that port 0;
  - t1_addrA port i = row;
  - both return to 0 in the next cycle unless a new read is accepted.
- Return pipeline: a per-port shift register of depth SRAM_DELAY carrying {vld, padr, oor}. It is loaded at the issue stage, so vread_vld_bus[i] is high in cycle N+1+SRAM_DELAY, for exactly one cycle per accepted read.
- Back-to-back reads: one read per port per cycle is fully pipelined with no bubbles. Outputs appear in acceptance order.
- Ports are independent. Simultaneous reads on all ports to the same bank are legal, since the array is multi-read capable.
- Zeros when idle: vread_padr_bus and vread_oor are 0 whenever the corresponding valid is 0.
- rd_cnt:
  - increments by 1 per accepted read;
  - saturates at 2^CNTW-1 and does not wrap;
  - is cleared only by rst.
- busy = OR of all issue-stage and pipeline valid bits. It does not include the cycle of acceptance.
- ready falling mid-flight: reads already accepted complete normally. Only new acceptance is blocked.

Test Plan:
1. SRAM_DELAY=2, ready=1; port0 reads addr 0x0015 at cycle 0 -> cycle 1: t1_readA port0=8'b0010_0000, t1_addrA=0x002; cycle 3: vread_vld_bus[0]=1, vread_padr_bus port0={3'd5,10'd2}, oor=0; rd_cnt[0]=1.
2. Port0 and port1 read every cycle for 20 cycles with incrementing addresses -> 20 contiguous valids per port starting at cycle 3, with padrs in issue order; busy deasserts at cycle 23.
3. NUMADDR=6000; read addr 6000 -> t1_readA port all-zero; vld=1 with oor=1 at N+3; rd_cnt increments.
4. pread=1 with ready=0 -> no t1_readA, no vld, rd_cnt unchanged; ready drops one cycle after an accepted read -> that read still returns.
5. rst asserted for one cycle at N+2 of an in-flight read -> outputs 0 immediately; no valid at N+3 or later.
6. CNTW=4; 20 accepted reads -> rd_cnt holds at 15.
